data_mem_bridge: RTL and testbench
==================================

# data_mem_bridge

Slave-side adapter between the multi-cycle CPU's memory request/response channels and a single-port synchronous data SRAM with configurable read latency. It accepts one CPU request at a time and applies writes with byte strobes in the accept cycle. For reads it waits out the SRAM latency and returns the full 32-bit word over a valid/ready response channel. It also keeps read/write access counters for the CPU performance-counter outputs.

## Interface

- `ADDR_W`, 14: SRAM word-address width; the SRAM holds 2^ADDR_W 32-bit words.
- `LATENCY`, 1: cycles from SRAM read enable to valid `ram_rdata`; legal range 1–8.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `Address` in 32: CPU byte address; bits [ADDR_W+1:2] select the word; all other bits ignored.
- `MemWrite` in 1: write request.
- `Write_data` in 32: write data.
- `Write_strb` in 4: byte enables; bit i enables byte lane i (bits [8i+7:8i]).
- `MemRead` in 1: read request.
- `Mem_Req_Ready` out 1: request accepted when it is high with `MemRead` or `MemWrite`.
- `Read_data` out 32: read response word, registered.
- `Read_data_Valid` out 1: response valid, registered.
- `Read_data_Ready` in 1: CPU accepts the response.
- `ram_en` out 1: SRAM enable.
- `ram_wen` out 4: SRAM byte write enables.
- `ram_addr` out ADDR_W: SRAM word address.
- `ram_wdata` out 32: SRAM write data.
- `ram_rdata` in 32: SRAM read data.
- `rd_cnt` out 32: count of accepted reads.
- `wr_cnt` out 32: count of accepted writes.

## Operation

**States**
- IDLE: ready for a new request.
- WAIT: read issued, latency counter running.
- RESP: response held.

**IDLE**
- `Mem_Req_Ready` = 1 while `rst` is deasserted; 0 in all other states and during reset.
- SRAM outputs are combinational from the request in IDLE.
  - `ram_addr` = `Address[ADDR_W+1:2]`.
  - `ram_wdata` = `Write_data`.
- Write (`MemWrite`=1):
  - `ram_en`=1, `ram_wen`=`Write_strb`.
  - `wr_cnt`+1; state stays IDLE.
  - Back-to-back writes are legal, one per cycle.
  - `Write_strb`=0 still counts but changes no data.
- Read (`MemRead`=1, `MemWrite`=0):
  - `ram_en`=1, `ram_wen`=0.
  - Latency counter loads LATENCY; `rd_cnt`+1; next state WAIT.
- Both `MemRead` and `MemWrite` high: the write is performed, the read is dropped, no response is produced, and only `wr_cnt` increments.
- Outside a write or read accept: `ram_en`=0, `ram_wen`=0.

**WAIT**
- Counter decrements each cycle.
- In the cycle where the counter equals 1, `ram_rdata` is captured into `Read_data` at the clock edge, `Read_data_Valid` is set, and the next state is RESP.

**RESP**
- `Read_data_Valid`=1; `Read_data` is stable.
- When `Read_data_Ready`=1: `Read_data_Valid` clears at the edge and the next state is IDLE.
- When `Read_data_Ready`=0: state and data are held indefinitely.

**Requests outside IDLE** are ignored: not accepted, not counted.

**Counters** wrap from 2^32−1 to 0.

**Reset (`rst`=0), at any time including mid-WAIT or mid-RESP**
- State goes to IDLE immediately and any pending read is discarded.
- `Read_data_Valid`=0, `Read_data`=0, latency counter=0, `rd_cnt`=0, `wr_cnt`=0.
- `ram_en`=0, `ram_wen`=0, `Mem_Req_Ready`=0.

## Timing

- Cycle numbering: the request-accept cycle is cycle 0.
- Write: SRAM written at the end of cycle 0. The next request can be accepted in cycle 1.
- Read:
  - WAIT occupies cycles 1..LATENCY.
  - `ram_rdata` is sampled at the end of cycle LATENCY.
  - `Read_data_Valid` is high from cycle LATENCY+1.
  - With `Read_data_Ready` already high, the handshake occurs in cycle LATENCY+1 and `Mem_Req_Ready` returns to 1 in cycle LATENCY+2.
  - Minimum read-to-read spacing: LATENCY+2 cycles.
- `rd_cnt` and `wr_cnt` update at the end of cycle 0.
- After reset release, a request can be accepted in the first cycle with `rst`=1.

## Test plan

- Write 0xFFFFFFFF to 0x100 with strobe 4'hF, then 0x12345678 to 0x100 with strobe 4'h3, then read 0x100 (LATENCY=1) -> `Read_data`=0xFFFF5678; `Read_data_Valid` in cycle 2; `wr_cnt`=2, `rd_cnt`=1.
- LATENCY=3, read 0x104 holding 0xCAFEBABE with Ready high -> `Read_data_Valid`=1 exactly in cycle 4 only; `Mem_Req_Ready`=0 in cycles 1–4, =1 in cycle 5.
- Read with `Read_data_Ready` low for 5 cycles, plus a new MemRead/MemWrite presented during the stall -> `Read_data` and Valid stable throughout; stall request not accepted (SRAM untouched, counters unchanged); handshake in the 6th response cycle.
- `MemRead`=`MemWrite`=1 to 0x200 with data 0xA5A5A5A5, strobe 4'hF -> word written; no `Read_data_Valid` within 10 cycles; `wr_cnt`+1, `rd_cnt` unchanged.
- Three consecutive-cycle writes to 0x0, 0x4, 0x8 -> all three stored; `wr_cnt`=3; `Mem_Req_Ready` high throughout.
- Pull `rst` low during WAIT (LATENCY=4, cycle 2) -> Valid stays 0 and counters read 0 immediately; after release, `Mem_Req_Ready`=1 and a fresh read returns correct data.

Source files
------------

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - CPU request/response to synchronous data SRAM bridge
// One request at a time; writes complete in the accept cycle, reads wait out LATENCY.
module data_mem_bridge #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Address,
  input  logic              MemWrite,
  input  logic [31:0]       Write_data,
  input  logic [3:0]        Write_strb,
  input  logic              MemRead,
  output logic              Mem_Req_Ready,
  output logic [31:0]       Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic        wr_acc, rd_acc;
  logic        unused_addr_bits;

  // A simultaneous read+write is treated as a write only.
  assign wr_acc = rst && (state_q == IDLE) && MemWrite;
  assign rd_acc = rst && (state_q == IDLE) && MemRead && !MemWrite;

  assign unused_addr_bits = ^{Address[31:ADDR_W+2], Address[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lat_q    <= 4'd0;
      rdata_q  <= 32'd0;
      valid_q  <= 1'b0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    rdata_d  = rdata_q;
    valid_d  = valid_q;
    rd_cnt_d = rd_cnt_q + {31'd0, rd_acc};
    wr_cnt_d = wr_cnt_q + {31'd0, wr_acc};
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          rdata_d = ram_rdata;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (Read_data_Ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Mem_Req_Ready   = rst && (state_q == IDLE);
    ram_en          = wr_acc || rd_acc;
    ram_wen         = wr_acc ? Write_strb : 4'h0;
    ram_addr        = Address[ADDR_W+1:2];
    ram_wdata       = Write_data;
    Read_data       = rdata_q;
    Read_data_Valid = valid_q;
    rd_cnt          = rd_cnt_q;
    wr_cnt          = wr_cnt_q;
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - self-checking bench for data_mem_bridge
// Three instances (LATENCY 1, 3, 4), each with its own latency-modelled SRAM.
module tb_data_mem_bridge;
  localparam int NI    = 3;
  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n      [NI];
  logic [31:0]   address    [NI];
  logic          mem_write  [NI];
  logic [31:0]   write_data [NI];
  logic [3:0]    write_strb [NI];
  logic          mem_read   [NI];
  logic          req_ready  [NI];
  logic [31:0]   read_data  [NI];
  logic          read_valid [NI];
  logic          read_ready [NI];
  logic          ram_en     [NI];
  logic [3:0]    ram_wen    [NI];
  logic [AW-1:0] ram_addr   [NI];
  logic [31:0]   ram_wdata  [NI];
  logic [31:0]   ram_rdata  [NI];
  logic [31:0]   rd_cnt     [NI];
  logic [31:0]   wr_cnt     [NI];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    logic [31:0] sram [WORDS];
    logic [31:0] pipe [L];

    data_mem_bridge #(.ADDR_W(AW), .LATENCY(L)) dut (
      .clk(clk), .rst(rst_n[g]), .Address(address[g]), .MemWrite(mem_write[g]),
      .Write_data(write_data[g]), .Write_strb(write_strb[g]), .MemRead(mem_read[g]),
      .Mem_Req_Ready(req_ready[g]), .Read_data(read_data[g]),
      .Read_data_Valid(read_valid[g]), .Read_data_Ready(read_ready[g]),
      .ram_en(ram_en[g]), .ram_wen(ram_wen[g]), .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g]),
      .rd_cnt(rd_cnt[g]), .wr_cnt(wr_cnt[g])
    );

    // SRAM: byte-masked write at the edge; read data emerges L cycles after enable.
    always @(posedge clk) begin
      if (ram_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[g][b]) sram[ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
      end
      pipe[0] <= (ram_en[g] && ram_wen[g] == 4'h0) ? sram[ram_addr[g]] : 32'hDEAD_BEEF;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata[g] = pipe[L-1];
  end

  logic [31:0] ref_mem [NI][WORDS];
  logic [31:0] ref_rd  [NI];
  logic [31:0] ref_wr  [NI];
  int n_run  = 0;
  int n_fail = 0;

  function automatic int lat(int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) & (WORDS - 1));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnts(int g, string tag);
    chk({tag, "_rd_cnt"}, rd_cnt[g], ref_rd[g]);
    chk({tag, "_wr_cnt"}, wr_cnt[g], ref_wr[g]);
  endtask

  task automatic wr(int g, logic [31:0] a, logic [31:0] d, logic [3:0] s, bit also_rd = 1'b0);
    int idx;
    idx = widx(a);
    @(negedge clk);
    address[g] = a; write_data[g] = d; write_strb[g] = s;
    mem_write[g] = 1'b1; mem_read[g] = also_rd;
    #1;
    chk("wr_req_ready", req_ready[g], 32'd1);
    chk("wr_ram_en", ram_en[g], 32'd1);
    chk("wr_ram_wen", ram_wen[g], s);
    chk("wr_ram_addr", ram_addr[g], idx);
    chk("wr_ram_wdata", ram_wdata[g], d);
    @(posedge clk); #1;
    mem_write[g] = 1'b0; mem_read[g] = 1'b0;
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[g][idx][8*b +: 8] = d[8*b +: 8];
    ref_wr[g]++;
    chk_cnts(g, "wr");
  endtask

  task automatic rd(int g, logic [31:0] a, int delay, bit intrude = 1'b0);
    int L;
    int idx;
    logic [31:0] exp;
    L = lat(g);
    idx = widx(a);
    exp = ref_mem[g][idx];
    @(negedge clk);
    address[g] = a; mem_read[g] = 1'b1; mem_write[g] = 1'b0; read_ready[g] = 1'b0;
    #1;
    chk("rd_req_ready", req_ready[g], 32'd1);
    chk("rd_ram_en", ram_en[g], 32'd1);
    chk("rd_ram_wen", ram_wen[g], 32'd0);
    chk("rd_ram_addr", ram_addr[g], idx);
    @(posedge clk); #1;
    mem_read[g] = 1'b0;
    ref_rd[g]++;
    chk_cnts(g, "rd");
    for (int k = 1; k <= L; k++) begin
      @(negedge clk); #1;
      chk("wait_valid", read_valid[g], 32'd0);
      chk("wait_req_ready", req_ready[g], 32'd0);
    end
    for (int r = 0; r <= delay; r++) begin
      @(negedge clk);
      read_ready[g] = (r == delay);
      if (intrude && r == 1) begin
        address[g] = a ^ 32'h4; write_data[g] = $urandom; write_strb[g] = 4'hF;
        mem_write[g] = 1'b1; mem_read[g] = 1'b1;
      end
      #1;
      chk("resp_valid", read_valid[g], 32'd1);
      chk("resp_data", read_data[g], exp);
      chk("resp_req_ready", req_ready[g], 32'd0);
      if (intrude && r == 1) chk("stall_ram_en", ram_en[g], 32'd0);
      @(posedge clk); #1;
      mem_write[g] = 1'b0; mem_read[g] = 1'b0;
      if (intrude && r == 1) chk_cnts(g, "stall");
    end
    @(negedge clk);
    read_ready[g] = 1'b0;
    #1;
    chk("post_valid", read_valid[g], 32'd0);
    chk("post_req_ready", req_ready[g], 32'd1);
    chk_cnts(g, "post");
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0; address[g] = 32'd0; mem_write[g] = 1'b0; write_data[g] = 32'd0;
      write_strb[g] = 4'h0; mem_read[g] = 1'b1; read_ready[g] = 1'b0;
      ref_rd[g] = 32'd0; ref_wr[g] = 32'd0;
      for (int i = 0; i < WORDS; i++) ref_mem[g][i] = 32'd0;
    end
    #2;
    for (int g = 0; g < NI; g++) begin
      chk("rst_req_ready", req_ready[g], 32'd0);
      chk("rst_ram_en", ram_en[g], 32'd0);
      chk("rst_valid", read_valid[g], 32'd0);
      chk("rst_data", read_data[g], 32'd0);
      chk_cnts(g, "rst");
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b1; mem_read[g] = 1'b0;
    end

    // Byte-strobe merge with LATENCY=1, then response timing with LATENCY=3.
    wr(0, 32'h100, 32'hFFFF_FFFF, 4'hF);
    wr(0, 32'h100, 32'h1234_5678, 4'h3);
    rd(0, 32'h100, 0);
    wr(1, 32'h104, 32'hCAFE_BABE, 4'hF);
    rd(1, 32'h104, 0);

    // Stalled response with an intruding request; the neighbour word must survive.
    wr(0, 32'h104, 32'h1111_2222, 4'hF);
    rd(0, 32'h100, 5, 1'b1);
    rd(0, 32'h104, 0);

    // Read and write together: write only, no response.
    wr(0, 32'h200, 32'hA5A5_A5A5, 4'hF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("both_no_valid", read_valid[0], 32'd0);
    end
    rd(0, 32'h200, 0);

    // Back-to-back writes, then reset in the middle of a LATENCY=4 read.
    wr(2, 32'h0, 32'h0000_0A0A, 4'hF);
    wr(2, 32'h4, 32'h0000_0B0B, 4'hF);
    wr(2, 32'h8, 32'h0000_0C0C, 4'hF);
    rd(2, 32'h0, 1);
    rd(2, 32'h4, 0);
    rd(2, 32'h8, 2);
    @(negedge clk);
    address[2] = 32'h4; mem_read[2] = 1'b1;
    @(posedge clk); #1;
    mem_read[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0; mem_read[2] = 1'b1; mem_write[2] = 1'b1; write_strb[2] = 4'hF;
    #1;
    ref_rd[2] = 32'd0; ref_wr[2] = 32'd0;
    chk("midrst_valid", read_valid[2], 32'd0);
    chk("midrst_data", read_data[2], 32'd0);
    chk("midrst_req_ready", req_ready[2], 32'd0);
    chk("midrst_ram_en", ram_en[2], 32'd0);
    chk("midrst_ram_wen", ram_wen[2], 32'd0);
    chk_cnts(2, "midrst");
    @(negedge clk);
    rst_n[2] = 1'b1; mem_read[2] = 1'b0; mem_write[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk("after_rst_valid", read_valid[2], 32'd0);
      chk("after_rst_req_ready", req_ready[2], 32'd1);
    end
    rd(2, 32'h4, 0);

    // Random traffic against the reference model; upper and low address bits are noise.
    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < 16; i++)
        wr(g, ($urandom & 32'hFFFF_F003) | (i << 2), $urandom, 4'hF);
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a;
        int op;
        a = ($urandom & 32'hFFFF_F003) | ($urandom_range(0, 15) << 2);
        op = $urandom_range(0, 3);
        if (op <= 1)      wr(g, a, $urandom, 4'($urandom_range(0, 15)));
        else if (op == 2) rd(g, a, $urandom_range(0, 3));
        else              wr(g, a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
